// File: rtl/seq_right_shift_8bit.sv
// Multi-cycle right shifter: shifts an operand right by 0..2**CNT_W-1 positions,
// one bit per clock, logical or arithmetic, with valid/ready on both sides.
module seq_right_shift_8bit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [CNT_W-1:0] B,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             C
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic             c_q, c_d;
  logic             accept;

  assign accept = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (B == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Fill bit is captured at accept so later changes on A/arith cannot leak in.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    fill_d = fill_q;
    c_d    = c_q;
    if (state_q == S_IDLE && accept) begin
      data_d = A;
      cnt_d  = B;
      fill_d = arith & A[WIDTH-1];
      c_d    = 1'b0;
    end else if (state_q == S_SHIFT) begin
      data_d = {fill_q, data_q[WIDTH-1:1]};
      cnt_d  = cnt_q - CNT_W'(1);
      c_d    = data_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      fill_q <= 1'b0;
      c_q    <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      c_q    <= c_d;
    end
  end

  assign Y = data_q;
  assign C = c_q;

endmodule

// File: tb/tb_seq_right_shift_8bit.sv
// Directed bench for seq_right_shift_8bit: vector table plus back-pressure and
// mid-shift reset sequences.
module tb_seq_right_shift_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [3:0] B;
  logic       arith;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Y;
  logic       C;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic       arith;
    logic [7:0] y;
    logic       c;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  seq_right_shift_8bit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .C         (C)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Presents one operand, counts edges (accept edge included) until out_valid,
  // optionally stalls in DONE for 'hold' cycles, then releases the result.
  task automatic run_op(input vec_t v, input int hold);
    int  lat;
    bit  got;
    @(negedge clk);
    check("in_ready before accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    A         = v.a;
    B         = v.b;
    arith     = v.arith;
    out_ready = (hold == 0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      in_valid = 1'b0;
      A        = ~v.a;
      B        = ~v.b;
      arith    = ~v.arith;
      if (out_valid) got = 1'b1;
    end
    check("out_valid seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(v.lat));
    check("Y", 32'(Y), 32'(v.y));
    check("C", 32'(C), 32'(v.c));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      A        = 8'(i * 37 + 5);
      B        = 4'(i + 1);
      @(posedge clk);
      #1;
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold Y", 32'(Y), 32'(v.y));
      check("hold C", 32'(C), 32'(v.c));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release out_valid", 32'(out_valid), 32'd0);
    check("release in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{a: 8'hB6, b: 4'd3,  arith: 1'b0, y: 8'h16, c: 1'b1, lat: 4};
    vecs[1] = '{a: 8'hB6, b: 4'd3,  arith: 1'b1, y: 8'hF6, c: 1'b1, lat: 4};
    vecs[2] = '{a: 8'h5A, b: 4'd0,  arith: 1'b0, y: 8'h5A, c: 1'b0, lat: 1};
    vecs[3] = '{a: 8'hFF, b: 4'd8,  arith: 1'b0, y: 8'h00, c: 1'b1, lat: 9};
    vecs[4] = '{a: 8'hFF, b: 4'd9,  arith: 1'b0, y: 8'h00, c: 1'b0, lat: 10};
    vecs[5] = '{a: 8'h80, b: 4'd15, arith: 1'b1, y: 8'hFF, c: 1'b1, lat: 16};
    vecs[6] = '{a: 8'h5A, b: 4'd0,  arith: 1'b1, y: 8'h5A, c: 1'b0, lat: 1};
    vecs[7] = '{a: 8'h81, b: 4'd1,  arith: 1'b1, y: 8'hC0, c: 1'b1, lat: 2};
    vecs[8] = '{a: 8'h7F, b: 4'd15, arith: 1'b1, y: 8'h00, c: 1'b0, lat: 16};

    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = 8'h00;
    B         = 4'd0;
    arith     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset Y", 32'(Y), 32'd0);
    check("reset C", 32'(C), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_op(vecs[i], 0);

    // Back-pressure: five stalled cycles in DONE with in_valid and A/B toggling.
    run_op(vecs[0], 5);

    // Reset mid-shift drops the operation; Y and C are nonzero just before it.
    @(negedge clk);
    in_valid  = 1'b1;
    A         = 8'hB6;
    B         = 4'd10;
    arith     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid-shift out_valid", 32'(out_valid), 32'd0);
    check("mid-shift Y", 32'(Y), 32'h16);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post-rst in_ready", 32'(in_ready), 32'd1);
    check("post-rst out_valid", 32'(out_valid), 32'd0);
    check("post-rst Y", 32'(Y), 32'd0);
    check("post-rst C", 32'(C), 32'd0);
    out_ready = 1'b0;
    v = '{a: 8'h40, b: 4'd2, arith: 1'b0, y: 8'h10, c: 1'b0, lat: 3};
    run_op(v, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
